// File: rtl/ads1118_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ads1118_pkg
// Purpose  : Shared FSM encoding, config-word field constants and the
//            config-word builder for the ADS1118 scan controller.
// Revision : 1.0 - initial release
// ============================================================================
package ads1118_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CS_SETUP  = 3'd1,
        ST_XFER      = 3'd2,
        ST_CS_HOLD   = 3'd3,
        ST_CONV_WAIT = 3'd4
    } state_t;

    localparam logic       c_OS        = 1'b1;   // start a single conversion
    localparam logic       c_MUX_SE    = 1'b1;   // MUX[2]=1 selects AINn vs GND
    localparam logic       c_MODE_SS   = 1'b1;
    localparam logic       c_TS_MODE   = 1'b0;
    localparam logic       c_PULL_UP   = 1'b1;
    localparam logic [1:0] c_NOP_VALID = 2'b01;  // only 01 makes the device latch the word
    localparam logic       c_RESERVED  = 1'b1;

    function automatic logic [15:0] ads1118_cfg(input logic [1:0] ch,
                                                input logic [2:0] pga,
                                                input logic [2:0] dr);
        return {c_OS, c_MUX_SE, ch, pga, c_MODE_SS, dr,
                c_TS_MODE, c_PULL_UP, c_NOP_VALID, c_RESERVED};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ads1118_ch_sel.sv
`default_nettype none
// ============================================================================
// Module   : ads1118_ch_sel
// Purpose  : Picks the next enabled channel strictly after cur_ch (mod 4).
// Revision : 1.0 - initial release
// ============================================================================
module ads1118_ch_sel (
    input  logic [3:0] ch_en,
    input  logic [1:0] cur_ch,
    output logic [1:0] next_ch
);

    // Walk offsets from farthest to nearest so the closest enabled channel
    // is the last one written; offset 4 wraps back to cur_ch itself.
    always_comb begin
        next_ch = cur_ch;
        for (int i = 4; i >= 1; i--) begin
            if (ch_en[2'(cur_ch + 2'(i))]) begin
                next_ch = 2'(cur_ch + 2'(i));
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ads1118_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ads1118_scan_ctrl
// Purpose  : Round-robin single-shot scheduler for the ADS1118 over a 16-bit
//            SPI frame engine; tags each lagging result with its channel.
// Revision : 1.0 - initial release
// ============================================================================
module ads1118_scan_ctrl
    import ads1118_pkg::*;
#(
    parameter int CS_SETUP_CYC  = 2,
    parameter int CS_HOLD_CYC   = 2,
    parameter int CONV_WAIT_CYC = 1200,
    parameter int TIMEOUT_CYC   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  ch_en,
    input  logic [2:0]  pga,
    input  logic [2:0]  dr,
    output logic        spi_go,
    output logic [15:0] spi_wrdat,
    input  logic [15:0] spi_rddat,
    input  logic        spi_ok,
    output logic        cs_n,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic [1:0]  res_ch,
    output logic        busy,
    output logic        err
);

    localparam int c_MAX_AB  = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int c_MAX_CD  = (CONV_WAIT_CYC > TIMEOUT_CYC) ? CONV_WAIT_CYC : TIMEOUT_CYC;
    localparam int c_CNT_MAX = (c_MAX_AB > c_MAX_CD) ? c_MAX_AB : c_MAX_CD;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    // Counter is loaded with N-1 so each interval spans exactly N cycles.
    localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(CS_SETUP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD  = c_CNT_W'(CS_HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LD  = c_CNT_W'(CONV_WAIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LD   = c_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_cur_ch;
    logic [1:0]         r_prev_ch;
    logic               r_prev_valid;

    logic [1:0]         w_next_ch;
    logic               w_can_start;
    logic               w_cnt_done;
    logic               w_launch;

    ads1118_ch_sel u_ch_sel (
        .ch_en   (ch_en),
        .cur_ch  (r_cur_ch),
        .next_ch (w_next_ch)
    );

    assign w_can_start = enable && (|ch_en);
    assign w_cnt_done  = (r_cnt == '0);
    assign w_launch    = w_can_start &&
                         ((r_state == ST_IDLE) || ((r_state == ST_CONV_WAIT) && w_cnt_done));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_cur_ch     <= 2'd3;
            r_prev_ch    <= 2'd0;
            r_prev_valid <= 1'b0;
            spi_go       <= 1'b0;
            spi_wrdat    <= 16'h0000;
            cs_n         <= 1'b1;
            res_valid    <= 1'b0;
            res_data     <= 16'h0000;
            res_ch       <= 2'd0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            spi_go    <= 1'b0;
            res_valid <= 1'b0;
            err       <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    busy <= 1'b0;
                end
                ST_CS_SETUP: begin
                    if (!w_cnt_done) begin
                        r_cnt <= r_cnt - c_ONE;
                    end else begin
                        spi_go  <= 1'b1;
                        r_cnt   <= c_TMO_LD;
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // A frame-done arriving on the last timeout cycle still completes the frame.
                    if (spi_ok) begin
                        if (r_prev_valid) begin
                            res_valid <= 1'b1;
                            res_data  <= spi_rddat;
                            res_ch    <= r_prev_ch;
                        end
                        r_prev_ch    <= r_cur_ch;
                        r_prev_valid <= 1'b1;
                        r_cnt        <= c_HOLD_LD;
                        r_state      <= ST_CS_HOLD;
                    end else if (w_cnt_done) begin
                        cs_n         <= 1'b1;
                        err          <= 1'b1;
                        r_prev_valid <= 1'b0;
                        busy         <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                ST_CS_HOLD: begin
                    if (!w_cnt_done) begin
                        r_cnt <= r_cnt - c_ONE;
                    end else begin
                        cs_n    <= 1'b1;
                        r_cnt   <= c_WAIT_LD;
                        r_state <= ST_CONV_WAIT;
                    end
                end
                ST_CONV_WAIT: begin
                    if (!w_cnt_done) begin
                        r_cnt <= r_cnt - c_ONE;
                    end else if (!w_can_start) begin
                        r_prev_valid <= 1'b0;
                        busy         <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_launch) begin
                r_cur_ch  <= w_next_ch;
                spi_wrdat <= ads1118_cfg(w_next_ch, pga, dr);
                cs_n      <= 1'b0;
                busy      <= 1'b1;
                r_cnt     <= c_SETUP_LD;
                r_state   <= ST_CS_SETUP;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ads1118_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ads1118_scan_ctrl
// Purpose  : Directed bench for ads1118_scan_ctrl with an ADS1118/SPI model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ads1118_scan_ctrl;

    localparam int N_LAT = 20;
    localparam int SETUP = 2;
    localparam int HOLD  = 2;
    localparam int CONV  = 40;
    localparam int TMO   = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  ch_en = 4'b0000;
    logic [2:0]  pga = 3'b001;
    logic [2:0]  dr = 3'b111;
    logic        spi_go;
    logic [15:0] spi_wrdat;
    logic [15:0] spi_rddat;
    logic        spi_ok;
    logic        cs_n;
    logic        res_valid;
    logic [15:0] res_data;
    logic [1:0]  res_ch;
    logic        busy;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;

    bit          mute = 1'b0;
    int          m_cnt = 0;
    bit          m_have = 1'b0;
    logic [1:0]  m_prev = 2'd0;
    logic [15:0] m_word = 16'h0000;

    ads1118_scan_ctrl #(
        .CS_SETUP_CYC  (SETUP),
        .CS_HOLD_CYC   (HOLD),
        .CONV_WAIT_CYC (CONV),
        .TIMEOUT_CYC   (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .ch_en     (ch_en),
        .pga       (pga),
        .dr        (dr),
        .spi_go    (spi_go),
        .spi_wrdat (spi_wrdat),
        .spi_rddat (spi_rddat),
        .spi_ok    (spi_ok),
        .cs_n      (cs_n),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ch    (res_ch),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Conversion value the model ADC holds for each input.
    function automatic logic [15:0] rd_word(input logic [1:0] ch);
        case (ch)
            2'd0:    return 16'h1234;
            2'd1:    return 16'hFEDC;
            2'd2:    return 16'h8000;
            default: return 16'h7FFF;
        endcase
    endfunction

    // Hand-computed config words for pga=001, dr=111.
    function automatic logic [15:0] cfg_exp(input logic [1:0] ch);
        case (ch)
            2'd0:    return 16'hC3EB;
            2'd1:    return 16'hD3EB;
            2'd2:    return 16'hE3EB;
            default: return 16'hF3EB;
        endcase
    endfunction

    // SPI engine + ADS1118: ok N_LAT cycles after go, returning the previous conversion.
    initial begin
        spi_ok = 1'b0;
        spi_rddat = 16'h0000;
        forever begin
            @(negedge clk);
            spi_ok = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    spi_ok = 1'b1;
                    spi_rddat = m_word;
                end
            end else if (spi_go && !mute) begin
                m_word = m_have ? rd_word(m_prev) : 16'hDEAD;
                m_prev = spi_wrdat[13:12];
                m_have = 1'b1;
                m_cnt = N_LAT;
            end
        end
    end

    task automatic do_reset();
        enable = 1'b0;
        rst = 1'b1;
        repeat (30) @(negedge clk);
        m_have = 1'b0;
        mute = 1'b0;
        rst = 1'b0;
    endtask

    task automatic wait_go(output bit to);
        int n;
        n = 0;
        to = 1'b0;
        @(negedge clk);
        while (!spi_go && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!spi_go) to = 1'b1;
    endtask

    // Follows a frame from its go cycle to the first cs_n-high cycle.
    task automatic watch_frame(output bit vld, output logic [1:0] ch,
                               output logic [15:0] data, output bit to);
        int n;
        n = 0;
        vld = 1'b0;
        ch = 2'd0;
        data = 16'h0000;
        do begin
            @(negedge clk);
            n++;
            if (res_valid) begin
                vld = 1'b1;
                ch = res_ch;
                data = res_data;
            end
        end while (!cs_n && n < 300);
        to = !cs_n;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (cs_n !== 1'b1)          begin n_bad++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
        n_vec++; if (spi_go !== 1'b0)        begin n_bad++; $display("FAIL reset_spi_go got %b want 0", spi_go); end
        n_vec++; if (spi_wrdat !== 16'h0)    begin n_bad++; $display("FAIL reset_wrdat got %h want 0000", spi_wrdat); end
        n_vec++; if (res_valid !== 1'b0)     begin n_bad++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        n_vec++; if (res_data !== 16'h0)     begin n_bad++; $display("FAIL reset_res_data got %h want 0000", res_data); end
        n_vec++; if (res_ch !== 2'd0)        begin n_bad++; $display("FAIL reset_res_ch got %0d want 0", res_ch); end
        n_vec++; if (busy !== 1'b0)          begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (err !== 1'b0)           begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b0;
    endtask

    // seq packs the expected channel of frame f in bits [2f+1:2f].
    task automatic scan_frames(input string name, input logic [3:0] en,
                               input int nf, input logic [15:0] seq);
        bit to, vld;
        logic [1:0] ch, exp_ch, prv_ch;
        logic [15:0] data;
        do_reset();
        pga = 3'b001;
        dr = 3'b111;
        ch_en = en;
        enable = 1'b1;
        for (int f = 0; f < nf; f++) begin
            exp_ch = seq[2*f +: 2];
            prv_ch = (f > 0) ? seq[2*(f-1) +: 2] : 2'd0;
            wait_go(to);
            n_vec++;
            if (to) begin n_bad++; $display("FAIL %s_go_timeout frame %0d got none want spi_go", name, f); break; end
            n_vec++;
            if (spi_wrdat !== cfg_exp(exp_ch)) begin
                n_bad++; $display("FAIL %s_wrdat frame %0d got %h want %h", name, f, spi_wrdat, cfg_exp(exp_ch));
            end
            watch_frame(vld, ch, data, to);
            n_vec++;
            if (to) begin n_bad++; $display("FAIL %s_cs_timeout frame %0d got cs_n=0 want 1", name, f); break; end
            n_vec++;
            if (vld !== (f > 0)) begin n_bad++; $display("FAIL %s_valid frame %0d got %b want %b", name, f, vld, (f > 0)); end
            if (f > 0 && vld) begin
                n_vec++;
                if (ch !== prv_ch) begin n_bad++; $display("FAIL %s_res_ch frame %0d got %0d want %0d", name, f, ch, prv_ch); end
                n_vec++;
                if (data !== rd_word(prv_ch)) begin
                    n_bad++; $display("FAIL %s_res_data frame %0d got %h want %h", name, f, data, rd_word(prv_ch));
                end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_single_ch();
        scan_frames("single", 4'b0001, 4, 16'h0000);
    endtask

    task automatic test_two_ch();
        scan_frames("two", 4'b0101, 4, {8'h00, 2'd2, 2'd0, 2'd2, 2'd0});
    endtask

    task automatic test_all_ch();
        scan_frames("all", 4'b1111, 6, {4'h0, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0});
    endtask

    task automatic test_timing();
        bit to, vld;
        logic [1:0] ch;
        logic [15:0] data;
        int n;
        do_reset();
        pga = 3'b010;
        dr = 3'b100;
        ch_en = 4'b0001;
        enable = 1'b1;
        wait_go(to);
        n_vec++; if (spi_wrdat !== 16'hC58B) begin n_bad++; $display("FAIL timing_wrdat got %h want c58b", spi_wrdat); end
        watch_frame(vld, ch, data, to);
        n_vec++; if (vld !== 1'b0) begin n_bad++; $display("FAIL timing_stale_valid got %b want 0", vld); end
        n = 1;
        while (cs_n === 1'b1 && n < 500) begin
            @(negedge clk);
            if (cs_n) n++;
        end
        n_vec++; if (n != CONV) begin n_bad++; $display("FAIL timing_cs_high got %0d want %0d", n, CONV); end
        n = 0;
        while (!spi_go && n < 50) begin @(negedge clk); n++; end
        n_vec++; if (n != SETUP) begin n_bad++; $display("FAIL timing_setup got %0d want %0d", n, SETUP); end
        n = 0;
        while (!res_valid && n < 100) begin @(negedge clk); n++; end
        n_vec++; if (n != N_LAT + 1) begin n_bad++; $display("FAIL timing_go_to_res got %0d want %0d", n, N_LAT + 1); end
        n = 0;
        while (!cs_n && n < 50) begin @(negedge clk); n++; end
        n_vec++; if (n != HOLD) begin n_bad++; $display("FAIL timing_hold got %0d want %0d", n, HOLD); end
        enable = 1'b0;
    endtask

    task automatic test_timeout();
        bit to, vld;
        logic [1:0] ch;
        logic [15:0] data;
        int n;
        do_reset();
        pga = 3'b001;
        dr = 3'b111;
        ch_en = 4'b0001;
        enable = 1'b1;
        for (int f = 0; f < 2; f++) begin
            wait_go(to);
            watch_frame(vld, ch, data, to);
        end
        n_vec++; if (vld !== 1'b1) begin n_bad++; $display("FAIL tmo_pre_valid got %b want 1", vld); end
        mute = 1'b1;
        wait_go(to);
        n = 0;
        while (!err && n < 200) begin @(negedge clk); n++; end
        n_vec++; if (n != TMO) begin n_bad++; $display("FAIL tmo_err_delay got %0d want %0d", n, TMO); end
        n_vec++; if (cs_n !== 1'b1) begin n_bad++; $display("FAIL tmo_cs_n got %b want 1", cs_n); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_busy got %b want 0", busy); end
        n_vec++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL tmo_res_valid got %b want 0", res_valid); end
        mute = 1'b0;
        wait_go(to);
        n_vec++; if (to || spi_wrdat !== 16'hC3EB) begin n_bad++; $display("FAIL tmo_restart_wrdat got %h want c3eb", spi_wrdat); end
        watch_frame(vld, ch, data, to);
        n_vec++; if (vld !== 1'b0) begin n_bad++; $display("FAIL tmo_after_valid got %b want 0", vld); end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        bit to, vld, saw;
        logic [1:0] ch;
        logic [15:0] data;
        int n;
        do_reset();
        pga = 3'b001;
        dr = 3'b111;
        ch_en = 4'b0001;
        enable = 1'b1;
        wait_go(to);
        watch_frame(vld, ch, data, to);
        wait_go(to);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        watch_frame(vld, ch, data, to);
        n_vec++; if (vld !== 1'b1) begin n_bad++; $display("FAIL drop_valid got %b want 1", vld); end
        n_vec++; if (data !== 16'h1234 || ch !== 2'd0) begin
            n_bad++; $display("FAIL drop_result got ch%0d %h want ch0 1234", ch, data);
        end
        n = 1;
        while (busy === 1'b1 && n < 500) begin
            @(negedge clk);
            if (busy) n++;
        end
        n_vec++; if (n != CONV) begin n_bad++; $display("FAIL drop_busy_fall got %0d want %0d", n, CONV); end
        n_vec++; if (cs_n !== 1'b1) begin n_bad++; $display("FAIL drop_cs_n got %b want 1", cs_n); end
        saw = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (spi_go || busy) saw = 1'b1;
        end
        n_vec++; if (saw !== 1'b0) begin n_bad++; $display("FAIL drop_stays_idle got %b want 0", saw); end
    endtask

    task automatic test_rst_mid();
        bit to, vld;
        logic [1:0] ch;
        logic [15:0] data;
        do_reset();
        pga = 3'b001;
        dr = 3'b111;
        ch_en = 4'b1111;
        enable = 1'b1;
        for (int f = 0; f < 2; f++) begin
            wait_go(to);
            watch_frame(vld, ch, data, to);
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (cs_n !== 1'b1)       begin n_bad++; $display("FAIL rstmid_cs_n got %b want 1", cs_n); end
        n_vec++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_vec++; if (res_data !== 16'h0)  begin n_bad++; $display("FAIL rstmid_res_data got %h want 0000", res_data); end
        n_vec++; if (spi_wrdat !== 16'h0) begin n_bad++; $display("FAIL rstmid_wrdat got %h want 0000", spi_wrdat); end
        n_vec++; if (res_ch !== 2'd0 || res_valid !== 1'b0 || spi_go !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_misc got ch%0d v%b g%b e%b want ch0 v0 g0 e0", res_ch, res_valid, spi_go, err);
        end
        wait_go(to);
        n_vec++; if (to || spi_wrdat !== 16'hC3EB) begin n_bad++; $display("FAIL rstmid_restart_wrdat got %h want c3eb", spi_wrdat); end
        watch_frame(vld, ch, data, to);
        n_vec++; if (vld !== 1'b0) begin n_bad++; $display("FAIL rstmid_first_valid got %b want 0", vld); end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_ch();
        test_two_ch();
        test_all_ch();
        test_timing();
        test_timeout();
        test_enable_drop();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ads1118_scan_ctrl.md
# ads1118_scan_ctrl

Round-robin conversion scheduler for the ADS1118 ADC. It sequences the existing 16-bit SPI frame engine (go/ok handshake) across up to four single-ended inputs (AIN0..AIN3). It drives chip-select, builds each single-shot config word, and waits out the conversion time. Because the ADS1118 returns the previous conversion during each frame, the block tags every returned result with the channel it belongs to. It sits between the SPI frame engine and downstream sample consumers, and runs in the engine's clock domain.

## Interface
- `CS_SETUP_CYC`, default 2: cycles `cs_n` is low before `spi_go`.
- `CS_HOLD_CYC`, default 2: cycles `cs_n` stays low after `spi_ok`.
- `CONV_WAIT_CYC`, default 1200: cycles `cs_n` is high between frames. Must cover the conversion time at the chosen DR.
- `TIMEOUT_CYC`, default 64: maximum cycles from `spi_go` to `spi_ok`.
- `clk` in 1: the clock shared with the SPI frame engine.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: run the scan while high.
- `ch_en` in 4: per-channel scan enable; bit n = AINn.
- `pga` in 3: PGA field for every frame.
- `dr` in 3: data-rate field for every frame.
- `spi_go` out 1: one-cycle start pulse to the engine.
- `spi_wrdat` out 16: config word for the frame.
- `spi_rddat` in 16: data shifted in; valid when `spi_ok`=1.
- `spi_ok` in 1: one-cycle frame-done pulse from the engine.
- `cs_n` out 1: ADS1118 chip-select, active low.
- `res_valid` out 1: one-cycle result strobe.
- `res_data` out 16: two's-complement conversion result.
- `res_ch` out 2: channel `res_data` belongs to.
- `busy` out 1: high whenever state is not IDLE.
- `err` out 1: one-cycle pulse on timeout.

## Operation
- Reset values: `cs_n`=1; `spi_go`, `spi_wrdat`, `res_valid`, `res_data`, `res_ch`, `busy`, `err` all =0. Internal state: `cur_ch`=3, `prev_valid`=0, state=IDLE.
- Config word fields, from MSB to LSB:
  - OS = 1
  - MUX = {1, ch[1:0]}
  - `pga`
  - MODE = 1 (single-shot)
  - `dr`
  - TS_MODE = 0
  - PULL_UP_EN = 1
  - NOP = 01
  - reserved = 1
- Channel select: the next channel is the next set bit of `ch_en` after `cur_ch`, scanning upward modulo 4. `ch_en` is sampled only at the select point.
- States:
  - **IDLE**:
    - Leave when `enable`=1 and `ch_en`≠0.
    - Select the next channel, latch `spi_wrdat` (including `pga`/`dr`), drive `cs_n` low, go to CS_SETUP.
  - **CS_SETUP**:
    - Count `CS_SETUP_CYC` cycles.
    - Then pulse `spi_go` for one cycle and go to XFER.
  - **XFER**:
    - Hold `spi_wrdat` stable and wait for `spi_ok`.
    - On `spi_ok`: if `prev_valid`=1, load `res_data` from `spi_rddat`, load `res_ch` from `prev_ch`, and pulse `res_valid`.
    - Then set `prev_ch` to `cur_ch`, set `prev_valid`=1, and go to CS_HOLD.
  - **CS_HOLD**:
    - Count `CS_HOLD_CYC` cycles, then set `cs_n` high and go to CONV_WAIT.
  - **CONV_WAIT**:
    - Count `CONV_WAIT_CYC` cycles.
    - Then, if `enable`=1 and `ch_en`≠0, select a channel and enter CS_SETUP as from IDLE.
    - Otherwise clear `prev_valid` and go to IDLE.
- First frame after IDLE returns stale data. It is discarded: `prev_valid`=0, so no `res_valid`.
- Timeout:
  - Trigger: XFER has lasted `TIMEOUT_CYC` cycles with no `spi_ok`.
  - Response: set `cs_n` high, pulse `err`, clear `prev_valid`, go to IDLE.
  - Restart is immediate if `enable` is still high.
- `enable` dropping mid-frame: the current frame completes normally, including its `res_valid`, and the block stops at the CONV_WAIT exit.
- `spi_ok` in any state other than XFER is ignored.
- `spi_ok` in the same cycle as the timeout: `spi_ok` wins.
- `rst` mid-operation: all outputs return to reset values on the next edge. `cs_n` goes high immediately, with no frame completion.

## Timing
- IDLE→CS_SETUP: `cs_n` falls on the edge that leaves IDLE.
- `spi_go` is high in cycle `CS_SETUP_CYC` after `cs_n` falls.
- `res_valid`, `res_data` and `res_ch` are registered and appear 1 cycle after the `spi_ok` cycle.
- `cs_n` rises `CS_HOLD_CYC`+1 cycles after `spi_ok`.
- `cs_n` high time between frames is exactly `CONV_WAIT_CYC` cycles.
- Frame period, with N = engine go→ok latency: `CS_SETUP_CYC` + N + 1 + `CS_HOLD_CYC` + `CONV_WAIT_CYC`.
- `err` and `res_valid` are never high in the same cycle.

## Structure
- Shared package `ads1118_pkg` holds:
  - state enum
  - config field constants: OS, MODE_SS, NOP_VALID, PULL_UP, reserved
  - a function `ads1118_cfg(ch, pga, dr)` returning the 16-bit word
- Natural sub-module: `ads1118_ch_sel`, combinational next-enabled-channel picker; inputs `ch_en` and `cur_ch`.
- A single shared down-counter serves the setup, hold, wait and timeout intervals.

## Test plan
- Bench: an SPI engine model with N=20 and fixed return words; for the timeout case the model is muted.
- ch_en=0001, pga=001, dr=111: every `spi_wrdat`=0xC3EB. First frame gives no `res_valid`; every later frame gives `res_valid` with `res_ch`=0 and `res_data` equal to the model word.
- ch_en=0101: `spi_wrdat` alternates 0xC3EB/0xE3EB. Results are tagged alternately ch0/ch2, lagging one frame.
- ch_en=1111: MUX sequence 100,101,110,111,100. `res_ch` sequence 0,1,2,3 with wrap-around.
- Model never asserts `spi_ok`: `err` pulses 64 cycles after `spi_go`, `cs_n` goes high, and the next frame produces no `res_valid`.
- Drop `enable` during XFER: that frame's result is delivered, then `busy` falls at the CONV_WAIT exit with `cs_n`=1. Separately, assert `rst` during CONV_WAIT: all outputs return to reset values next cycle.
